// File: rtl/mpu_matrix_regfile_pkg.sv
// Shared sizing, dimension types and stream FSM states for the MPU matrix register file.
package mpu_matrix_regfile_pkg;
  localparam int FP               = 32;
  localparam int M                = 4;
  localparam int N                = 4;
  localparam int MBITS            = $clog2(M);
  localparam int NBITS            = $clog2(N);
  localparam int MATRIX_REG_SIZE  = 2;
  localparam int MATRIX_REGISTERS = 2**MATRIX_REG_SIZE;

  typedef logic [MBITS:0] mdim_t;
  typedef logic [NBITS:0] ndim_t;
  typedef logic [FP-1:0]  elem_t;

  localparam mdim_t M_MAX = mdim_t'(M);
  localparam ndim_t N_MAX = ndim_t'(N);

  typedef enum logic {RF_IDLE, RF_STREAM} regfile_state_t;

  // True when (r,c) is the final element of an ms x ns matrix in row-major order.
  function automatic logic is_last(mdim_t r, ndim_t c, mdim_t ms, ndim_t ns);
    return (r == ms - mdim_t'(1)) && (c == ns - ndim_t'(1));
  endfunction
endpackage

// File: rtl/mpu_matrix_regfile_stream_ctr.sv
// Row-major row/column position counter; exposes current and next position for one-cycle-ahead fetch.
module mpu_matrix_regfile_stream_ctr
  import mpu_matrix_regfile_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr_i,
  input  logic  adv_i,
  input  mdim_t m_size_i,
  input  ndim_t n_size_i,
  output mdim_t row_o,
  output ndim_t col_o,
  output mdim_t nxt_row_o,
  output ndim_t nxt_col_o,
  output logic  last_o,
  output logic  nxt_last_o
);
  mdim_t row_q, row_d;
  ndim_t col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q + ndim_t'(1);
    if (col_q == n_size_i - ndim_t'(1)) begin
      col_d = '0;
      row_d = row_q + mdim_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (adv_i) begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o      = row_q;
  assign col_o      = col_q;
  assign nxt_row_o  = row_d;
  assign nxt_col_o  = col_d;
  assign last_o     = is_last(row_q, col_q, m_size_i, n_size_i);
  assign nxt_last_o = is_last(row_d, col_d, m_size_i, n_size_i);
endmodule

// File: rtl/mpu_matrix_regfile.sv
// Matrix register file: element-stream write port from the load stage, row-major streaming read port.
module mpu_matrix_regfile
  import mpu_matrix_regfile_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reg_load_en,
  input  logic [MATRIX_REG_SIZE-1:0]  reg_load_addr,
  input  logic [MBITS:0]              reg_m_out,
  input  logic [NBITS:0]              reg_n_out,
  input  logic [MBITS:0]              reg_m_size,
  input  logic [NBITS:0]              reg_n_size,
  input  logic [FP-1:0]               reg_element_out,
  output logic                        wr_error,
  input  logic                        rd_req,
  input  logic [MATRIX_REG_SIZE-1:0]  rd_addr,
  output logic                        rd_ack,
  output logic                        rd_error,
  output logic                        rd_valid,
  output logic [FP-1:0]               rd_element,
  output logic [MBITS:0]              rd_row,
  output logic [NBITS:0]              rd_col,
  output logic                        rd_last,
  output logic [MBITS:0]              rd_m_size,
  output logic [NBITS:0]              rd_n_size,
  output logic [MATRIX_REGISTERS-1:0] slot_valid
);
  elem_t                       mem_q [MATRIX_REGISTERS][M][N];
  mdim_t                       msize_q [MATRIX_REGISTERS];
  ndim_t                       nsize_q [MATRIX_REGISTERS];
  logic [MATRIX_REGISTERS-1:0] slot_valid_q;

  regfile_state_t              state_q;
  logic [MATRIX_REG_SIZE-1:0]  slot_q;
  mdim_t                       rd_m_size_q;
  ndim_t                       rd_n_size_q;
  elem_t                       rd_element_q;
  logic                        wr_error_q, rd_ack_q, rd_error_q, rd_valid_q, rd_last_q;

  logic  wr_ok, wr_first, wr_final, accept, abort, adv;
  mdim_t ctr_row, ctr_nrow;
  ndim_t ctr_col, ctr_ncol;
  logic  ctr_last, ctr_nlast;

  always_comb begin
    wr_ok    = reg_load_en
             && (reg_m_size != '0) && (reg_n_size != '0)
             && (reg_m_size <= M_MAX) && (reg_n_size <= N_MAX)
             && (reg_m_out < reg_m_size) && (reg_n_out < reg_n_size);
    wr_first = (reg_m_out == '0) && (reg_n_out == '0);
    wr_final = is_last(reg_m_out, reg_n_out, reg_m_size, reg_n_size);
    accept   = (state_q == RF_IDLE) && rd_req && slot_valid_q[rd_addr];
    abort    = wr_ok && (state_q == RF_STREAM) && (reg_load_addr == slot_q);
    adv      = (state_q == RF_STREAM) && !abort && !ctr_last;
  end

  mpu_matrix_regfile_stream_ctr u_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (accept),
    .adv_i      (adv),
    .m_size_i   (rd_m_size_q),
    .n_size_i   (rd_n_size_q),
    .row_o      (ctr_row),
    .col_o      (ctr_col),
    .nxt_row_o  (ctr_nrow),
    .nxt_col_o  (ctr_ncol),
    .last_o     (ctr_last),
    .nxt_last_o (ctr_nlast)
  );

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem_q[reg_load_addr][reg_m_out[MBITS-1:0]][reg_n_out[NBITS-1:0]] <= reg_element_out;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_valid_q <= '0;
      wr_error_q   <= 1'b0;
      for (int i = 0; i < MATRIX_REGISTERS; i++) begin
        msize_q[i] <= '0;
        nsize_q[i] <= '0;
      end
    end else begin
      wr_error_q <= reg_load_en && !wr_ok;
      if (wr_ok) begin
        if (wr_first) begin
          msize_q[reg_load_addr]      <= reg_m_size;
          nsize_q[reg_load_addr]      <= reg_n_size;
          slot_valid_q[reg_load_addr] <= 1'b0;
        end
        // Later assignment lets a 1x1 write leave the slot valid.
        if (wr_final)
          slot_valid_q[reg_load_addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RF_IDLE;
      slot_q       <= '0;
      rd_m_size_q  <= '0;
      rd_n_size_q  <= '0;
      rd_element_q <= '0;
      rd_ack_q     <= 1'b0;
      rd_error_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      rd_ack_q   <= 1'b0;
      rd_error_q <= 1'b0;
      case (state_q)
        RF_IDLE: begin
          rd_valid_q <= 1'b0;
          rd_last_q  <= 1'b0;
          if (rd_req) begin
            if (slot_valid_q[rd_addr]) begin
              state_q      <= RF_STREAM;
              slot_q       <= rd_addr;
              rd_m_size_q  <= msize_q[rd_addr];
              rd_n_size_q  <= nsize_q[rd_addr];
              rd_ack_q     <= 1'b1;
              rd_valid_q   <= 1'b1;
              rd_element_q <= mem_q[rd_addr][0][0];
              rd_last_q    <= is_last('0, '0, msize_q[rd_addr], nsize_q[rd_addr]);
            end else begin
              rd_error_q <= 1'b1;
            end
          end
        end
        RF_STREAM: begin
          if (abort) begin
            state_q    <= RF_IDLE;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_error_q <= 1'b1;
          end else if (ctr_last) begin
            state_q    <= RF_IDLE;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
          end else begin
            rd_element_q <= mem_q[slot_q][ctr_nrow[MBITS-1:0]][ctr_ncol[NBITS-1:0]];
            rd_last_q    <= ctr_nlast;
          end
        end
      endcase
    end
  end

  assign wr_error   = wr_error_q;
  assign rd_ack     = rd_ack_q;
  assign rd_error   = rd_error_q;
  assign rd_valid   = rd_valid_q;
  assign rd_element = rd_element_q;
  assign rd_row     = ctr_row;
  assign rd_col     = ctr_col;
  assign rd_last    = rd_last_q;
  assign rd_m_size  = rd_m_size_q;
  assign rd_n_size  = rd_n_size_q;
  assign slot_valid = slot_valid_q;
endmodule

// File: tb/tb_mpu_matrix_regfile.sv
// Scenario bench for mpu_matrix_regfile against an array-based model of slot contents and flags.
module tb_mpu_matrix_regfile;
  import mpu_matrix_regfile_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst;
  logic                        reg_load_en;
  logic [MATRIX_REG_SIZE-1:0]  reg_load_addr;
  logic [MBITS:0]              reg_m_out, reg_m_size;
  logic [NBITS:0]              reg_n_out, reg_n_size;
  logic [FP-1:0]               reg_element_out;
  logic                        wr_error;
  logic                        rd_req;
  logic [MATRIX_REG_SIZE-1:0]  rd_addr;
  logic                        rd_ack, rd_error, rd_valid, rd_last;
  logic [FP-1:0]               rd_element;
  logic [MBITS:0]              rd_row, rd_m_size;
  logic [NBITS:0]              rd_col, rd_n_size;
  logic [MATRIX_REGISTERS-1:0] slot_valid;

  int n_cmp = 0;
  int n_fail = 0;

  int unsigned                 mdl_mem [MATRIX_REGISTERS][M][N];
  int                          mdl_m [MATRIX_REGISTERS];
  int                          mdl_n [MATRIX_REGISTERS];
  bit [MATRIX_REGISTERS-1:0]   mdl_valid;

  mpu_matrix_regfile dut (
    .clk(clk), .rst(rst),
    .reg_load_en(reg_load_en), .reg_load_addr(reg_load_addr),
    .reg_m_out(reg_m_out), .reg_n_out(reg_n_out),
    .reg_m_size(reg_m_size), .reg_n_size(reg_n_size),
    .reg_element_out(reg_element_out), .wr_error(wr_error),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_error(rd_error),
    .rd_valid(rd_valid), .rd_element(rd_element), .rd_row(rd_row), .rd_col(rd_col),
    .rd_last(rd_last), .rd_m_size(rd_m_size), .rd_n_size(rd_n_size),
    .slot_valid(slot_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_write(int a, int r, int c, int ms, int ns, int unsigned d);
    bit ok;
    ok = (ms >= 1) && (ms <= M) && (ns >= 1) && (ns <= N) && (r < ms) && (c < ns);
    if (ok) begin
      mdl_mem[a][r][c] = d;
      if (r == 0 && c == 0) begin
        mdl_m[a] = ms;
        mdl_n[a] = ns;
        mdl_valid[a] = 1'b0;
      end
      if (r == ms - 1 && c == ns - 1) mdl_valid[a] = 1'b1;
    end
    return ok;
  endfunction

  task automatic drive_write(int a, int r, int c, int ms, int ns, int unsigned d);
    reg_load_en     = 1'b1;
    reg_load_addr   = MATRIX_REG_SIZE'(a);
    reg_m_out       = (MBITS+1)'(r);
    reg_n_out       = (NBITS+1)'(c);
    reg_m_size      = (MBITS+1)'(ms);
    reg_n_size      = (NBITS+1)'(ns);
    reg_element_out = d;
  endtask

  task automatic write_elem(int a, int r, int c, int ms, int ns, int unsigned d);
    bit ok;
    drive_write(a, r, c, ms, ns, d);
    tick();
    reg_load_en = 1'b0;
    ok = model_write(a, r, c, ms, ns, d);
    n_cmp++;
    if (wr_error !== !ok) begin
      n_fail++;
      $display("FAIL wr_error slot%0d (%0d,%0d) size %0dx%0d: got %b want %b", a, r, c, ms, ns, wr_error, !ok);
    end
    n_cmp++;
    if (slot_valid !== mdl_valid) begin
      n_fail++;
      $display("FAIL slot_valid after write: got %b want %b", slot_valid, mdl_valid);
    end
  endtask

  task automatic load_matrix(int a, int ms, int ns);
    for (int r = 0; r < ms; r++)
      for (int c = 0; c < ns; c++)
        write_elem(a, r, c, ms, ns, $urandom);
  endtask

  task automatic stream_check(int a);
    int ms, ns, r, c;
    bit v;
    v  = mdl_valid[a];
    ms = mdl_m[a];
    ns = mdl_n[a];
    rd_req  = 1'b1;
    rd_addr = MATRIX_REG_SIZE'(a);
    tick();
    rd_req = 1'b0;
    if (!v) begin
      n_cmp++;
      if (rd_error !== 1'b1 || rd_ack !== 1'b0 || rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL invalid_req slot%0d: err=%b ack=%b vld=%b want 1/0/0", a, rd_error, rd_ack, rd_valid);
      end
      tick();
      n_cmp++;
      if (rd_error !== 1'b0 || rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL invalid_req_after slot%0d: err=%b vld=%b want 0/0", a, rd_error, rd_valid);
      end
    end else begin
      for (int k = 0; k < ms * ns; k++) begin
        r = k / ns;
        c = k % ns;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_ack !== ((k == 0) ? 1'b1 : 1'b0) || rd_error !== 1'b0
            || rd_row !== (MBITS+1)'(r) || rd_col !== (NBITS+1)'(c)
            || rd_element !== mdl_mem[a][r][c]
            || rd_last !== ((k == ms * ns - 1) ? 1'b1 : 1'b0)
            || rd_m_size !== (MBITS+1)'(ms) || rd_n_size !== (NBITS+1)'(ns)) begin
          n_fail++;
          $display("FAIL stream slot%0d k=%0d: vld=%b ack=%b err=%b rc=(%0d,%0d) d=%h last=%b sz=%0dx%0d want rc=(%0d,%0d) d=%h sz=%0dx%0d",
                   a, k, rd_valid, rd_ack, rd_error, rd_row, rd_col, rd_element, rd_last,
                   rd_m_size, rd_n_size, r, c, mdl_mem[a][r][c], ms, ns);
        end
        tick();
      end
      n_cmp++;
      if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_end slot%0d: vld=%b last=%b want 0/0", a, rd_valid, rd_last);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    reg_load_en = 1'b0; reg_load_addr = '0; reg_m_out = '0; reg_n_out = '0;
    reg_m_size = '0; reg_n_size = '0; reg_element_out = '0;
    rd_req = 1'b0; rd_addr = '0;
    mdl_valid = '0;
    for (int i = 0; i < MATRIX_REGISTERS; i++) begin
      mdl_m[i] = 0;
      mdl_n[i] = 0;
    end
    repeat (3) tick();
    n_cmp++;
    if ({wr_error, rd_ack, rd_error, rd_valid, rd_last} !== 5'b0 || rd_element !== '0
        || rd_row !== '0 || rd_col !== '0 || rd_m_size !== '0 || rd_n_size !== '0 || slot_valid !== '0) begin
      n_fail++;
      $display("FAIL reset_state: flags=%b d=%h sv=%b want all zero",
               {wr_error, rd_ack, rd_error, rd_valid, rd_last}, rd_element, slot_valid);
    end
    rst = 1'b1;
    tick();
    stream_check(2);
  endtask

  task automatic test_basic();
    int unsigned vals [6];
    vals = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};
    for (int k = 0; k < 6; k++) write_elem(1, k / 3, k % 3, 2, 3, vals[k]);
    stream_check(1);
  endtask

  task automatic test_multi();
    load_matrix(3, 4, 4);
    write_elem(0, 0, 0, 1, 1, $urandom);
    stream_check(3);
    stream_check(0);
  endtask

  task automatic test_wr_reject();
    write_elem(1, 0, 0, 5, 3, $urandom);
    write_elem(1, 2, 0, 2, 3, $urandom);
    write_elem(1, 0, 0, 0, 2, $urandom);
    write_elem(1, 0, 4, 2, 4, $urandom);
    stream_check(1);
  endtask

  task automatic test_abort();
    int unsigned d;
    rd_req = 1'b1; rd_addr = 2'd1;
    tick();
    rd_req = 1'b0;
    n_cmp++;
    if (rd_ack !== 1'b1 || rd_valid !== 1'b1 || rd_element !== mdl_mem[1][0][0]) begin
      n_fail++;
      $display("FAIL abort_start: ack=%b vld=%b d=%h want 1/1/%h", rd_ack, rd_valid, rd_element, mdl_mem[1][0][0]);
    end
    d = $urandom;
    drive_write(2, 0, 0, 2, 2, d);
    tick();
    reg_load_en = 1'b0;
    void'(model_write(2, 0, 0, 2, 2, d));
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_col !== 3'd1 || rd_element !== mdl_mem[1][0][1] || wr_error !== 1'b0) begin
      n_fail++;
      $display("FAIL other_slot_write: vld=%b col=%0d d=%h wr_err=%b want 1/1/%h/0", rd_valid, rd_col, rd_element, wr_error, mdl_mem[1][0][1]);
    end
    tick();
    tick();
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_row !== 3'd1 || rd_col !== 3'd0 || rd_element !== mdl_mem[1][1][0]) begin
      n_fail++;
      $display("FAIL abort_elem3: vld=%b rc=(%0d,%0d) d=%h want 1 (1,0) %h", rd_valid, rd_row, rd_col, rd_element, mdl_mem[1][1][0]);
    end
    d = $urandom;
    drive_write(1, 0, 0, 2, 3, d);
    tick();
    reg_load_en = 1'b0;
    void'(model_write(1, 0, 0, 2, 3, d));
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_error !== 1'b1 || slot_valid !== mdl_valid) begin
      n_fail++;
      $display("FAIL abort: vld=%b err=%b sv=%b want 0/1/%b", rd_valid, rd_error, slot_valid, mdl_valid);
    end
    tick();
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_error !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after: vld=%b err=%b want 0/0", rd_valid, rd_error);
    end
    stream_check(1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      load_matrix($urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(1, 4));
      write_elem($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 5), $urandom_range(0, 5), $urandom);
      stream_check($urandom_range(0, 3));
      stream_check($urandom_range(0, 3));
    end
  endtask

  task automatic test_mid_reset();
    load_matrix(3, 4, 4);
    rd_req = 1'b1; rd_addr = 2'd3;
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_col !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_reset_pre: vld=%b col=%0d want 1/2", rd_valid, rd_col);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mdl_valid = '0;
    for (int i = 0; i < MATRIX_REGISTERS; i++) begin
      mdl_m[i] = 0;
      mdl_n[i] = 0;
    end
    n_cmp++;
    if ({wr_error, rd_ack, rd_error, rd_valid, rd_last} !== 5'b0 || rd_element !== '0
        || rd_m_size !== '0 || rd_n_size !== '0 || slot_valid !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: flags=%b d=%h sv=%b want all zero",
               {wr_error, rd_ack, rd_error, rd_valid, rd_last}, rd_element, slot_valid);
    end
    stream_check(3);
    stream_check(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_wr_reject();
    test_abort();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mpu_matrix_regfile.md
Name: mpu_matrix_regfile

Overview:
Matrix register file sitting directly downstream of the MPU load stage. It holds MATRIX_REGISTERS matrices of up to M x N FP-bit elements. Each slot carries its own dimension and valid registers. A write port consumes the load stage's element stream, and a streaming read port feeds the store/compute stages one element per cycle, in row-major order.

Parameters:
FP, 32, element width (bits)
M, 4, max rows
N, 4, max columns
MBITS, $clog2(M), row index/size MSB (fields are [MBITS:0])
NBITS, $clog2(N), column index/size MSB (fields are [NBITS:0])
MATRIX_REG_SIZE, 2, slot address width
MATRIX_REGISTERS, 2**MATRIX_REG_SIZE, number of slots

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-low
reg_load_en  in  1  write strobe from load stage
reg_load_addr  in  MATRIX_REG_SIZE  write slot
reg_m_out  in  MBITS+1  write row index
reg_n_out  in  NBITS+1  write column index
reg_m_size  in  MBITS+1  matrix rows
reg_n_size  in  NBITS+1  matrix columns
reg_element_out  in  FP  write data
wr_error  out  1  one-cycle pulse: rejected write
rd_req  in  1  stream request, sampled only in RF_IDLE
rd_addr  in  MATRIX_REG_SIZE  slot to stream
rd_ack  out  1  one-cycle pulse: request accepted
rd_error  out  1  one-cycle pulse: request on invalid slot, or stream aborted
rd_valid  out  1  rd_element is valid
rd_element  out  FP  streamed element
rd_row  out  MBITS+1  row of rd_element
rd_col  out  NBITS+1  column of rd_element
rd_last  out  1  final element of the stream
rd_m_size  out  MBITS+1  rows of the streamed matrix (held through the stream)
rd_n_size  out  NBITS+1  columns of the streamed matrix
slot_valid  out  MATRIX_REGISTERS  per-slot complete flag

Behaviour:
- Outputs: all are registered. While rst==0 at a clk edge, every output goes to 0, slot_valid clears, stored sizes go to 0, and the FSM enters RF_IDLE. Element storage is not reset.
- Write, registered at the edge where reg_load_en==1:
  - Reject when reg_m_out>=reg_m_size, reg_n_out>=reg_n_size, reg_m_size>M, reg_n_size>N, or either size is 0. A rejected write sets wr_error=1 for the next cycle and changes no state.
  - An accepted write stores the element at [addr][row][col].
  - If row==0 and col==0: also capture the sizes for that slot and clear slot_valid[addr].
  - If row==size_m-1 and col==size_n-1: set slot_valid[addr] on the same edge.
  - When a write both clears and sets the flag (a 1x1 matrix), set wins.
- FSM states: RF_IDLE, RF_STREAM.
- RF_IDLE, rd_req==1 at edge t:
  - If slot_valid[rd_addr]==0: rd_error=1 at t+1, stay in RF_IDLE.
  - Otherwise: latch the slot and its sizes, go to RF_STREAM, and set rd_ack=1 at t+1.
  - At t+1 the first element (0,0) is also presented with rd_valid=1.
- RF_STREAM: one element per cycle, column index increments first and wraps to 0 at n_size, then the row increments.
  - Element k appears at t+1+k, for k = 0..m*n-1.
  - rd_last=1 on element m*n-1. The next edge returns to RF_IDLE with rd_valid=0.
  - rd_req is ignored while in RF_STREAM, so the earliest new request is sampled one cycle after rd_last.
- No backpressure on either port.
- Write to the slot being streamed (accepted write, same address, during RF_STREAM):
  - The write completes normally.
  - The stream aborts: on the next cycle rd_valid=0, rd_error=1, and the FSM is in RF_IDLE.
  - Writes to other slots never disturb a stream.
- Read of a slot written on the same edge returns the old data. Acceptance of a request uses slot_valid as it was before that edge.
- rst==0 mid-stream: the next cycle shows rd_valid=0 and all slots are invalid.

Decomposition:
- global_defs (existing): FP, M, N, MBITS, NBITS, MATRIX_REG_SIZE, MATRIX_REGISTERS.
- mpu_pkg gains regfile_state_t {RF_IDLE, RF_STREAM}.
- One natural sub-module: mpu_stream_ctr, a row/column counter with size inputs, a load/clear input, and a wrap/last output.

Test Plan:
- Load 2x3 into slot 1 (elements 1.0..6.0), then rd_req slot 1 -> rd_ack at t+1; rd_valid for 6 cycles with (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); data 1.0..6.0; rd_last on the 6th; rd_m_size=2, rd_n_size=3.
- Load 4x4 into slot 3 and 1x1 into slot 0 -> slot_valid=4'b1001; streaming slot 3 gives 16 elements; streaming slot 0 gives one element with rd_ack, rd_valid and rd_last all at t+1.
- After reset, rd_req slot 2 -> rd_error=1 at t+1; no rd_ack; rd_valid stays 0.
- Write with reg_m_size=5, or with row 2 when the size is 2 -> wr_error pulse; slot_valid unchanged; stored data unchanged.
- Stream slot 1, then at element 3 write (0,0) to slot 1 -> next cycle rd_valid=0, rd_error=1; slot_valid[1]=0; a write to slot 2 mid-stream does not abort.
- Drive rst low during element 2 of a stream -> next cycle all outputs 0 and slot_valid=0; a subsequent rd_req returns rd_error.
